axi2mem_wr_sched: RTL

Write-side sequencer between the AXI write-data buffer pop ports and two 32-bit TCDM master ports.
- Accepts one AW burst command at a time.
- Per 64-bit beat: pops one word per lane and issues the TCDM writes at beat_addr and beat_addr+4.
- Counts outstanding TCDM responses.
- Returns an AXI B response once every write of the burst has been acknowledged.

---
 rtl/axi2mem_wr_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/axi2mem_wr_sched.sv
// AXI write-burst sequencer: pops two 32-bit lane words per beat, issues TCDM writes, returns B.
// Optional: define AXI2MEM_WR_SCHED_STRB_SKIP_EN to pop all-zero-strobe words without a TCDM write.
module axi2mem_wr_sched #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]       cmd_len_i,
    input  logic [ID_WIDTH-1:0]        cmd_id_i,
    input  logic [1:0][31:0]           wr_data_pop_dat_i,
    input  logic [1:0][3:0]            wr_data_pop_strb_i,
    input  logic [1:0]                 wr_data_pop_gnt_i,
    output logic [1:0]                 wr_data_pop_req_o,
    output logic [1:0]                 tcdm_req_o,
    output logic [1:0][ADDR_WIDTH-1:0] tcdm_add_o,
    output logic [1:0]                 tcdm_wen_o,
    output logic [1:0][3:0]            tcdm_be_o,
    output logic [1:0][31:0]           tcdm_wdata_o,
    input  logic [1:0]                 tcdm_gnt_i,
    input  logic [1:0]                 tcdm_r_valid_i,
    output logic                       b_valid_o,
    input  logic                       b_ready_i,
    output logic [ID_WIDTH-1:0]        b_id_o
);

    localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {StIdle, StWrite, StDrain, StResp} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    beat_q, beat_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [1:0]              done_q, done_d;
    logic [1:0][CntW-1:0]    outst_q, outst_d;
    logic                    alive_q;
    logic [1:0]              fire, skip, lane_done;
    logic                    unused_addr_lsb;

    assign unused_addr_lsb = ^cmd_addr_i[2:0];
    assign tcdm_wen_o      = 2'b00;

    // Per-lane issue, pop and outstanding-response tracking.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            skip[i] = 1'b0;
`ifdef AXI2MEM_WR_SCHED_STRB_SKIP_EN
            skip[i] = (state_q == StWrite) & wr_data_pop_gnt_i[i] & ~done_q[i] &
                      (wr_data_pop_strb_i[i] == 4'b0000);
`endif
            tcdm_req_o[i] = (state_q == StWrite) & wr_data_pop_gnt_i[i] & ~done_q[i] &
                            (outst_q[i] < CntW'(MAX_OUTST)) & ~skip[i];
            fire[i]              = tcdm_req_o[i] & tcdm_gnt_i[i];
            wr_data_pop_req_o[i] = fire[i] | skip[i];
            outst_d[i]           = outst_q[i];
            if (fire[i] && !tcdm_r_valid_i[i]) begin
                outst_d[i] = outst_q[i] + CntW'(1);
            end else if (!fire[i] && tcdm_r_valid_i[i] && (outst_q[i] != '0)) begin
                outst_d[i] = outst_q[i] - CntW'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        id_d         = id_q;
        beat_d       = beat_q;
        done_d       = done_q;
        cmd_ready_o  = 1'b0;
        b_valid_o    = 1'b0;
        b_id_o       = '0;
        tcdm_add_o   = '0;
        tcdm_be_o    = '0;
        tcdm_wdata_o = '0;
        lane_done    = done_q | wr_data_pop_req_o;

        case (state_q)
            StIdle: begin
                cmd_ready_o = alive_q;
                if (cmd_valid_i && alive_q) begin
                    addr_d  = {cmd_addr_i[ADDR_WIDTH-1:3], 3'b000};
                    len_d   = cmd_len_i;
                    id_d    = cmd_id_i;
                    beat_d  = '0;
                    done_d  = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                tcdm_add_o[0] = addr_q;
                tcdm_add_o[1] = addr_q + ADDR_WIDTH'(4);
                tcdm_be_o     = wr_data_pop_strb_i;
                tcdm_wdata_o  = wr_data_pop_dat_i;
                // A beat retires only once both lanes have taken their word.
                if (&lane_done) begin
                    done_d = '0;
                    addr_d = addr_q + ADDR_WIDTH'(8);
                    beat_d = beat_q + LEN_WIDTH'(1);
                    if (beat_q == len_q) begin
                        state_d = StDrain;
                    end
                end else begin
                    done_d = lane_done;
                end
            end
            StDrain: begin
                if (outst_d == '0) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                b_valid_o = 1'b1;
                b_id_o    = id_q;
                if (b_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            beat_q  <= '0;
            done_q  <= '0;
            outst_q <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            outst_q <= outst_d;
            alive_q <= 1'b1;
        end
    end

    // An acknowledge with nothing outstanding is a TCDM protocol error.
    a_lane0_ack: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(tcdm_r_valid_i[0] && !fire[0] && (outst_q[0] == '0)));
    a_lane1_ack: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(tcdm_r_valid_i[1] && !fire[1] && (outst_q[1] == '0)));

endmodule
